// File: rtl/int_clint.sv
// ============================================================================
// Module      : int_clint
// Description : Core-local interruptor with msip, 64-bit mtime and mtimecmp,
//               reached through a single-outstanding valid/ready slave port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_clint #(
   parameter int          TICK_DIV  = 1,
   parameter logic [15:0] BASE_MSIP = 16'h0000,
   parameter logic [15:0] BASE_CMP  = 16'h4000,
   parameter logic [15:0] BASE_TIME = 16'hBFF8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_clint_valid,
   output logic        clint_bus_ready,
   input  logic        bus_clint_wr,
   input  logic [15:0] bus_clint_addr,
   input  logic [31:0] bus_clint_wdata,
   output logic        clint_bus_rvalid,
   input  logic        bus_clint_rready,
   output logic [31:0] clint_bus_rdata,
   output logic        clint_bus_err,
   output logic        clint_int_tmr,
   output logic        clint_int_sft
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   localparam logic [15:0] c_word_mask = 16'hFFFC;
   localparam logic [15:0] c_msip      = BASE_MSIP & c_word_mask;
   localparam logic [15:0] c_cmp_lo    = BASE_CMP & c_word_mask;
   localparam logic [15:0] c_cmp_hi    = (BASE_CMP + 16'd4) & c_word_mask;
   localparam logic [15:0] c_time_lo   = BASE_TIME & c_word_mask;
   localparam logic [15:0] c_time_hi   = (BASE_TIME + 16'd4) & c_word_mask;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_accept;
   logic        w_wr;
   logic        w_tick;
   logic [15:0] w_addr;
   logic        w_sel_msip;
   logic        w_sel_cmp_lo;
   logic        w_sel_cmp_hi;
   logic        w_sel_time_lo;
   logic        w_sel_time_hi;
   logic        w_mapped;
   logic [31:0] w_rd_val;

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_msip;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        r_int_tmr;
   logic        r_int_sft;

   // ------------------------------------------------------------------
   // Request/response handshake
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      clint_bus_ready  = 1'b0;
      clint_bus_rvalid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            clint_bus_ready = 1'b1;
            if (bus_clint_valid) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            clint_bus_rvalid = 1'b1;
            if (bus_clint_rready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept = bus_clint_valid && clint_bus_ready;
   assign w_wr     = w_accept && bus_clint_wr;

   // ------------------------------------------------------------------
   // Register map decode (address bits [1:0] are don't-care)
   // ------------------------------------------------------------------
   assign w_addr        = bus_clint_addr & c_word_mask;
   assign w_sel_msip    = (w_addr == c_msip);
   assign w_sel_cmp_lo  = (w_addr == c_cmp_lo);
   assign w_sel_cmp_hi  = (w_addr == c_cmp_hi);
   assign w_sel_time_lo = (w_addr == c_time_lo);
   assign w_sel_time_hi = (w_addr == c_time_hi);
   assign w_mapped      = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                          w_sel_time_lo | w_sel_time_hi;

   always_comb begin
      w_rd_val = 32'd0;
      if (w_sel_msip)    w_rd_val = {31'd0, r_msip};
      if (w_sel_cmp_lo)  w_rd_val = r_mtimecmp[31:0];
      if (w_sel_cmp_hi)  w_rd_val = r_mtimecmp[63:32];
      if (w_sel_time_lo) w_rd_val = r_mtime[31:0];
      if (w_sel_time_hi) w_rd_val = r_mtime[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_rdata <= (bus_clint_wr || !w_mapped) ? 32'd0 : w_rd_val;
         r_err   <= !w_mapped;
      end
   end

   // ------------------------------------------------------------------
   // Tick prescaler
   // ------------------------------------------------------------------
   generate
      if (TICK_DIV <= 1) begin : g_tick_every
         assign w_tick = 1'b1;
      end else begin : g_prescale
         localparam int                c_pw   = $clog2(TICK_DIV);
         localparam logic [c_pw-1:0]   c_last = c_pw'(TICK_DIV - 1);
         logic [c_pw-1:0]              r_presc;

         assign w_tick = (r_presc == c_last);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_presc <= '0;
            end else if (w_tick) begin
               r_presc <= '0;
            end else begin
               r_presc <= r_presc + c_pw'(1);
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Timer, compare and software-interrupt registers
   // ------------------------------------------------------------------
   // A bus write to either mtime half suppresses that cycle's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtime <= 64'd0;
      end else if (w_wr && w_sel_time_lo) begin
         r_mtime[31:0] <= bus_clint_wdata;
      end else if (w_wr && w_sel_time_hi) begin
         r_mtime[63:32] <= bus_clint_wdata;
      end else if (w_tick) begin
         r_mtime <= r_mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_msip     <= 1'b0;
      end else begin
         if (w_wr && w_sel_cmp_lo) r_mtimecmp[31:0]  <= bus_clint_wdata;
         if (w_wr && w_sel_cmp_hi) r_mtimecmp[63:32] <= bus_clint_wdata;
         if (w_wr && w_sel_msip)   r_msip            <= bus_clint_wdata[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int_tmr <= 1'b0;
         r_int_sft <= 1'b0;
      end else begin
         r_int_tmr <= (r_mtime >= r_mtimecmp);
         r_int_sft <= r_msip;
      end
   end

   assign clint_bus_rdata = r_rdata;
   assign clint_bus_err   = r_err;
   assign clint_int_tmr   = r_int_tmr;
   assign clint_int_sft   = r_int_sft;

endmodule

`default_nettype wire

// File: tb/tb_int_clint.sv
// ============================================================================
// Module      : tb_int_clint
// Description : Randomized scoreboard bench for int_clint against a register-map model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_int_clint;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_clint_valid = 1'b0;
   logic        clint_bus_ready;
   logic        bus_clint_wr = 1'b0;
   logic [15:0] bus_clint_addr = 16'd0;
   logic [31:0] bus_clint_wdata = 32'd0;
   logic        clint_bus_rvalid;
   logic        bus_clint_rready = 1'b0;
   logic [31:0] clint_bus_rdata;
   logic        clint_bus_err;
   logic        clint_int_tmr;
   logic        clint_int_sft;

   int_clint #(.TICK_DIV(TD)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus_clint_valid  (bus_clint_valid),
      .clint_bus_ready  (clint_bus_ready),
      .bus_clint_wr     (bus_clint_wr),
      .bus_clint_addr   (bus_clint_addr),
      .bus_clint_wdata  (bus_clint_wdata),
      .clint_bus_rvalid (clint_bus_rvalid),
      .bus_clint_rready (bus_clint_rready),
      .clint_bus_rdata  (clint_bus_rdata),
      .clint_bus_err    (clint_bus_err),
      .clint_int_tmr    (clint_int_tmr),
      .clint_int_sft    (clint_int_sft)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t sb_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
      n_vec++;
      if (act !== ex) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, ex, $time);
      end
   endtask

   // Reference model: architectural register state, stepped once per clock.
   // At each falling edge the inputs and outputs are stable, so the model
   // checks the state reached at the last rising edge and predicts the next.
   logic [63:0]     m_time, m_cmp;
   logic            m_msip, m_busy, e_tmr, e_sft;
   longint unsigned m_cyc;

   always @(negedge clk) begin
      logic [15:0] a;
      logic [31:0] r;
      logic        e, wr_hit, tick;
      logic [63:0] nt;
      if (rst) begin
         m_time = 64'd0;
         m_cmp  = '1;
         m_msip = 1'b0;
         m_busy = 1'b0;
         e_tmr  = 1'b0;
         e_sft  = 1'b0;
         m_cyc  = 0;
         sb_q.delete();
         chk("rst_ready",  {63'd0, clint_bus_ready}, 64'd1);
         chk("rst_rvalid", {63'd0, clint_bus_rvalid}, 64'd0);
         chk("rst_rdata",  {32'd0, clint_bus_rdata}, 64'd0);
         chk("rst_err",    {63'd0, clint_bus_err}, 64'd0);
         chk("rst_tmr",    {63'd0, clint_int_tmr}, 64'd0);
         chk("rst_sft",    {63'd0, clint_int_sft}, 64'd0);
      end else begin
         chk("int_tmr", {63'd0, clint_int_tmr}, {63'd0, e_tmr});
         chk("int_sft", {63'd0, clint_int_sft}, {63'd0, e_sft});
         chk("ready",   {63'd0, clint_bus_ready}, {63'd0, !m_busy});
         chk("rvalid",  {63'd0, clint_bus_rvalid}, {63'd0, m_busy});

         // Prediction for the coming rising edge.
         e_tmr  = (m_time >= m_cmp);
         e_sft  = m_msip;
         wr_hit = 1'b0;
         a      = bus_clint_addr & 16'hFFFC;
         if (m_busy) begin
            if (bus_clint_rready) m_busy = 1'b0;
         end else if (bus_clint_valid) begin
            r = 32'd0;
            e = 1'b0;
            case (a)
               16'h0000: r = {31'd0, m_msip};
               16'h4000: r = m_cmp[31:0];
               16'h4004: r = m_cmp[63:32];
               16'hBFF8: r = m_time[31:0];
               16'hBFFC: r = m_time[63:32];
               default:  e = 1'b1;
            endcase
            if (bus_clint_wr) r = 32'd0;
            sb_q.push_back('{rdata: r, err: e});
            wr_hit = bus_clint_wr && !e;
            m_busy = 1'b1;
         end
         tick  = ((m_cyc % TD) == TD - 1);
         m_cyc = m_cyc + 1;
         nt    = m_time;
         if (wr_hit && a == 16'hBFF8)      nt[31:0]  = bus_clint_wdata;
         else if (wr_hit && a == 16'hBFFC) nt[63:32] = bus_clint_wdata;
         else if (tick)                    nt        = m_time + 64'd1;
         m_time = nt;
         if (wr_hit && a == 16'h4000) m_cmp[31:0]  = bus_clint_wdata;
         if (wr_hit && a == 16'h4004) m_cmp[63:32] = bus_clint_wdata;
         if (wr_hit && a == 16'h0000) m_msip       = bus_clint_wdata[0];
      end
   end

   // Monitor: pops the expected response whenever a response is consumed.
   always @(negedge clk) begin
      resp_t er;
      if (!rst && clint_bus_rvalid && bus_clint_rready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_unexpected: got rdata %h err %b, expected no response",
                     clint_bus_rdata, clint_bus_err);
         end else begin
            er = sb_q.pop_front();
            chk("rdata", {32'd0, clint_bus_rdata}, {32'd0, er.rdata});
            chk("err",   {63'd0, clint_bus_err}, {63'd0, er.err});
         end
      end
   end

   // ------------------------------------------------------------------
   // Driver (inputs change 1ns after the rising edge)
   // ------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
      bit acc = 1'b0;
      bus_clint_valid = 1'b1;
      bus_clint_wr    = w;
      bus_clint_addr  = a;
      bus_clint_wdata = d;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         if (clint_bus_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
      bus_clint_valid = 1'b0;
      bus_clint_wr    = 1'($urandom);
      bus_clint_addr  = 16'($urandom);
      bus_clint_wdata = $urandom;
   endtask

   task automatic collect(input int dly);
      bit got = 1'b0;
      bus_clint_rready = 1'b0;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk("hold_rvalid", {63'd0, clint_bus_rvalid}, 64'd1);
         chk("hold_ready",  {63'd0, clint_bus_ready}, 64'd0);
         @(posedge clk);
         #1;
      end
      bus_clint_rready = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (clint_bus_rvalid) got = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!got) chk("resp_timeout", 64'd0, 64'd1);
      bus_clint_rready = 1'b0;
   endtask

   task automatic op(input logic w, input logic [15:0] a, input logic [31:0] d, input int dly);
      issue(w, a, d);
      collect(dly);
   endtask

   logic [15:0] addr_tab [7] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                                 16'hBFFC, 16'h0100, 16'h4002};

   initial begin
      idle(3);
      rst = 1'b0;
      idle(2);

      // Reset in the middle of a pending response.
      issue(1'b0, 16'h4004, 32'd0);
      idle(2);
      rst = 1'b1;
      #1;
      chk("async_rvalid", {63'd0, clint_bus_rvalid}, 64'd0);
      chk("async_ready",  {63'd0, clint_bus_ready}, 64'd1);
      chk("async_tmr",    {63'd0, clint_int_tmr}, 64'd0);
      idle(2);
      rst = 1'b0;
      op(1'b0, 16'h4004, 32'd0, 0);

      // Free-running count with prescale of 4.
      do_reset();
      idle(40);
      op(1'b0, 16'hBFF8, 32'd0, 0);
      op(1'b0, 16'hBFF8, 32'd0, 1);

      // Carry from lo into hi, then full 64-bit wrap.
      op(1'b1, 16'hBFFC, 32'd0, 0);
      op(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 0);
      idle(8);
      op(1'b0, 16'hBFFC, 32'd0, 0);
      op(1'b0, 16'hBFF8, 32'd0, 0);
      op(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 0);
      op(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 0);
      idle(8);
      op(1'b0, 16'hBFFC, 32'd0, 0);
      op(1'b0, 16'hBFF8, 32'd0, 0);

      // Timer interrupt rise at compare, fall on compare rewrite.
      do_reset();
      op(1'b1, 16'h4004, 32'd0, 0);
      op(1'b1, 16'h4000, 32'd20, 0);
      idle(100);
      op(1'b1, 16'h4004, 32'd1, 0);
      idle(3);

      // Software interrupt.
      op(1'b1, 16'h0000, 32'hFFFF_FFFF, 0);
      idle(2);
      op(1'b0, 16'h0000, 32'd0, 0);
      op(1'b1, 16'h0000, 32'd0, 0);
      idle(2);

      // Response hold, unmapped offsets, mtime write against tick phases.
      op(1'b0, 16'h4000, 32'd0, 5);
      op(1'b0, 16'h0100, 32'd0, 0);
      op(1'b1, 16'h0100, 32'hDEAD_BEEF, 2);
      for (int k = 0; k < TD; k++) begin
         idle(k);
         op(1'b1, 16'hBFF8, 32'h1234_0000 + k, 0);
         op(1'b0, 16'hBFF8, 32'd0, 0);
      end

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         idle($urandom_range(0, 3));
         if ($urandom_range(0, 40) == 0) begin
            issue(1'($urandom), addr_tab[$urandom_range(0, 6)], $urandom);
            idle($urandom_range(0, 2));
            do_reset();
         end else begin
            op(1'($urandom), addr_tab[$urandom_range(0, 6)], $urandom, $urandom_range(0, 3));
         end
      end

      idle(3);
      chk("queue_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
